// File: rtl/rs_derand_pkg.sv
// Shared constants, state type and PRBS stepping helper for the DVB energy-dispersal derandomizer.
package rs_derand_pkg;

  localparam logic [7:0]  SYNC_BYTE      = 8'h47;
  localparam logic [7:0]  SYNC_INV       = 8'hB8;
  localparam logic [14:0] PRBS_INIT      = 15'h4A80;
  localparam int          PKT_LEN_DEF    = 188;
  localparam int          GROUP_PKTS_DEF = 8;
  localparam int          MISS_LIMIT_DEF = 3;

  typedef enum logic {HUNT, LOCKED} state_t;

  typedef struct packed {
    logic [14:0] state;
    logic [7:0]  data;
  } prbs_adv_t;

  // Bit 14 holds r1 and bit 0 holds r15; the first feedback bit lands in the byte MSB.
  function automatic prbs_adv_t prbs_advance8(input logic [14:0] s);
    prbs_adv_t r;
    logic [14:0] t;
    logic o;
    r = '0;
    t = s;
    for (int i = 0; i < 8; i++) begin
      o      = t[1] ^ t[0];
      r.data = {r.data[6:0], o};
      t      = {o, t[14:1]};
    end
    r.state = t;
    return r;
  endfunction

endpackage

// File: rtl/prbs_byte_gen.sv
// 1+x^14+x^15 energy-dispersal generator, advancing one byte (8 bits) per step8.
module prbs_byte_gen
  import rs_derand_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step8,
  output logic [7:0] prbs_byte
);

  logic [14:0] lfsr;
  prbs_adv_t   adv;

  assign adv       = prbs_advance8(lfsr);
  assign prbs_byte = adv.data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= PRBS_INIT;
    end else if (load) begin
      lfsr <= PRBS_INIT;
    end else if (step8) begin
      lfsr <= adv.state;
    end
  end

endmodule

// File: rtl/rs_derandomizer.sv
// DVB RS(204,188) receive-side derandomizer: hunts for the inverted sync, strips the PRBS, flags sync errors.
// Optional build macro SYNC_RELOCK_EN: drop lock after MISS_LIMIT consecutive bad sync bytes.
module rs_derandomizer
  import rs_derand_pkg::*;
#(
  parameter int PKT_LEN    = PKT_LEN_DEF,
  parameter int GROUP_PKTS = GROUP_PKTS_DEF
`ifdef SYNC_RELOCK_EN
  ,
  parameter int MISS_LIMIT = MISS_LIMIT_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       Valid_in,
  input  logic [7:0] input_byte,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out,
  output logic       Pkt_start,
  output logic       Sync_err
);

  localparam int BW = $clog2(PKT_LEN);
  localparam int PW = (GROUP_PKTS > 1) ? $clog2(GROUP_PKTS) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);
  localparam logic [PW-1:0] LAST_PKT  = PW'(GROUP_PKTS - 1);

  state_t        state, state_nxt;
  logic [BW-1:0] byte_cnt, byte_cnt_nxt;
  logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
  logic [7:0]    out_nxt;
  logic          ceo_nxt, vld_nxt, pkt_start_nxt, sync_err_nxt;
  logic          accept, prbs_load, prbs_step, sync_bad;
  logic [7:0]    sync_exp, prbs_byte;

`ifdef SYNC_RELOCK_EN
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);
  logic [MW-1:0] miss_cnt, miss_nxt;
`endif

  assign accept   = CE && Valid_in;
  assign sync_exp = (pkt_cnt == '0) ? SYNC_INV : SYNC_BYTE;
  assign sync_bad = (input_byte != sync_exp);

  prbs_byte_gen u_prbs (
    .clk       (clk),
    .reset     (reset),
    .load      (prbs_load),
    .step8     (prbs_step),
    .prbs_byte (prbs_byte)
  );

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    pkt_cnt_nxt   = pkt_cnt;
    out_nxt       = Out_byte;
    ceo_nxt       = 1'b0;
    vld_nxt       = Valid_out;
    pkt_start_nxt = 1'b0;
    sync_err_nxt  = 1'b0;
    prbs_load     = 1'b0;
    prbs_step     = 1'b0;
`ifdef SYNC_RELOCK_EN
    miss_nxt      = miss_cnt;
`endif
    if (accept) begin
      case (state)
        HUNT: begin
          if (input_byte == SYNC_INV) begin
            prbs_load     = 1'b1;
            pkt_cnt_nxt   = '0;
            byte_cnt_nxt  = BW'(1);
            state_nxt     = LOCKED;
            out_nxt       = SYNC_BYTE;
            ceo_nxt       = 1'b1;
            pkt_start_nxt = 1'b1;
            vld_nxt       = 1'b1;
`ifdef SYNC_RELOCK_EN
            miss_nxt      = '0;
`endif
          end
        end
        LOCKED: begin
          ceo_nxt = 1'b1;
          vld_nxt = 1'b1;
          if (byte_cnt == '0) begin
            // A bad sync is reported but treated as the expected one for counting and PRBS.
            out_nxt       = SYNC_BYTE;
            pkt_start_nxt = 1'b1;
            sync_err_nxt  = sync_bad;
            byte_cnt_nxt  = BW'(1);
            if (pkt_cnt == '0) prbs_load = 1'b1;
            else               prbs_step = 1'b1;
`ifdef SYNC_RELOCK_EN
            if (!sync_bad) begin
              miss_nxt = '0;
            end else if (miss_cnt == MISS_LAST) begin
              miss_nxt  = '0;
              state_nxt = HUNT;
              vld_nxt   = 1'b0;
            end else begin
              miss_nxt = miss_cnt + MW'(1);
            end
`endif
          end else begin
            out_nxt   = input_byte ^ prbs_byte;
            prbs_step = 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt_nxt = '0;
              pkt_cnt_nxt  = (pkt_cnt == LAST_PKT) ? '0 : pkt_cnt + PW'(1);
            end else begin
              byte_cnt_nxt = byte_cnt + BW'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      byte_cnt  <= '0;
      pkt_cnt   <= '0;
      Out_byte  <= '0;
      CEO       <= 1'b0;
      Valid_out <= 1'b0;
      Pkt_start <= 1'b0;
      Sync_err  <= 1'b0;
`ifdef SYNC_RELOCK_EN
      miss_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      pkt_cnt   <= pkt_cnt_nxt;
      Out_byte  <= out_nxt;
      CEO       <= ceo_nxt;
      Valid_out <= vld_nxt;
      Pkt_start <= pkt_start_nxt;
      Sync_err  <= sync_err_nxt;
`ifdef SYNC_RELOCK_EN
      miss_cnt  <= miss_nxt;
`endif
    end
  end

endmodule
